layer1_write_act: RTL and testbench

Ping-pong activation writer for Layer 1. Consumes the 64-bit `reluRes` AXI-Stream produced by Layer 0 and packs fixed-size tiles into alternating halves of the Layer 1 activation BRAM. After each tile it hands the bank to the Layer 1 PE over an `ap_vld`/`ap_ack` sync channel, and reclaims the bank when the PE releases it. Layer 0 back-pressure arises only when both banks are occupied or a handoff is pending.

---
 rtl/layer1_write_act_pkg.sv | 14 +
 rtl/layer1_write_act_if.sv | 40 ++++
 rtl/layer1_write_act_bank_tracker.sv | 33 +++
 rtl/layer1_write_act.sv | 118 +++++++++++
 tb/tb_layer1_write_act.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/layer1_write_act_pkg.sv
// Shared types and default geometry for the Layer 1 activation writer.
package layer1_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    NOTIFY = 2'd1,
    WAIT   = 2'd2
  } l1_state_e;

  localparam int L1_DWIDTH     = 64;
  localparam int L1_AWIDTH     = 10;
  localparam int L1_TILE_WORDS = 384;

endpackage

// File: rtl/layer1_write_act_if.sv
// Stream, PE sync channel and BRAM write port of the Layer 1 activation writer.
interface layer1_write_act_if
  import layer1_pkg::*;
#(
  parameter int DWIDTH = L1_DWIDTH,
  parameter int AWIDTH = L1_AWIDTH
);

  logic [DWIDTH-1:0] reluRes_V_Data_V_TDATA;
  logic              reluRes_V_Data_V_TVALID;
  logic              reluRes_V_Data_V_TREADY;
  logic              SyncSig_V;
  logic              SyncSig_V_ap_vld;
  logic              SyncSig_V_ap_ack;
  logic              Release_V;
  logic              Release_V_ap_vld;
  logic [AWIDTH-1:0] ActBuf_Data_V_address0;
  logic              ActBuf_Data_V_ce0;
  logic              ActBuf_Data_V_we0;
  logic [DWIDTH-1:0] ActBuf_Data_V_d0;

  modport master (
    input  reluRes_V_Data_V_TDATA, reluRes_V_Data_V_TVALID,
    output reluRes_V_Data_V_TREADY,
    output SyncSig_V, SyncSig_V_ap_vld,
    input  SyncSig_V_ap_ack,
    input  Release_V, Release_V_ap_vld,
    output ActBuf_Data_V_address0, ActBuf_Data_V_ce0, ActBuf_Data_V_we0, ActBuf_Data_V_d0
  );

  modport slave (
    output reluRes_V_Data_V_TDATA, reluRes_V_Data_V_TVALID,
    input  reluRes_V_Data_V_TREADY,
    input  SyncSig_V, SyncSig_V_ap_vld,
    output SyncSig_V_ap_ack,
    output Release_V, Release_V_ap_vld,
    input  ActBuf_Data_V_address0, ActBuf_Data_V_ce0, ActBuf_Data_V_we0, ActBuf_Data_V_d0
  );

endinterface

// File: rtl/layer1_write_act_bank_tracker.sv
// Occupancy flags of the two ping-pong banks; a handoff set beats a release
// of the same bank, while set and clear of different banks both apply.
module layer1_bank_tracker (
  input  logic       clk,
  input  logic       rst,
  input  logic       setEn,
  input  logic       setIdx,
  input  logic       clrEn,
  input  logic       clrIdx,
  output logic [1:0] busyNext_s
);

  logic [1:0] busy_r;

  // Next occupancy: set dominates clear on the same bank.
  always_comb begin
    busyNext_s = 2'b00;
    for (int i = 0; i < 2; i++) begin
      busyNext_s[i] = (setEn && (setIdx == i[0])) ||
                      (busy_r[i] && !(clrEn && (clrIdx == i[0])));
    end
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 2'b00;
    end else begin
      busy_r <= busyNext_s;
    end
  end

endmodule

// File: rtl/layer1_write_act.sv
// Ping-pong activation writer: packs reluRes beats into alternating BRAM banks
// and hands each completed tile to the Layer 1 PE over the ap_vld/ap_ack channel.
module layer1_write_act
  import layer1_pkg::*;
#(
  parameter int DWIDTH     = L1_DWIDTH,
  parameter int AWIDTH     = L1_AWIDTH,
  parameter int TILE_WORDS = L1_TILE_WORDS
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  layer1_write_act_if.master   bus,
  output logic [15:0]          tile_cnt
);

  localparam logic [AWIDTH-2:0] LAST_OFF = (AWIDTH-1)'(TILE_WORDS - 1);
  localparam logic [AWIDTH-2:0] OFF_STEP = {{(AWIDTH-2){1'b0}}, 1'b1};

  l1_state_e         state_r;
  l1_state_e         nextState_s;
  logic              curBank_r;
  logic [AWIDTH-2:0] offset_r;
  logic              ready_r;
  logic              vld_r;
  logic              sync_r;
  logic              ce_r;
  logic [AWIDTH-1:0] addr_r;
  logic [DWIDTH-1:0] data_r;
  logic [15:0]       tileCnt_r;
  logic              accept_s;
  logic              lastBeat_s;
  logic              ackTake_s;
  logic [1:0]        busyNext_s;

  // ready_r is high only in FILL, so it alone qualifies an accept.
  assign accept_s   = bus.reluRes_V_Data_V_TVALID & ready_r;
  assign lastBeat_s = accept_s && (offset_r == LAST_OFF);
  assign ackTake_s  = (state_r == NOTIFY) && bus.SyncSig_V_ap_ack;

  layer1_bank_tracker u_tracker (
    .clk        (ap_clk),
    .rst        (ap_rst),
    .setEn      (ackTake_s),
    .setIdx     (curBank_r),
    .clrEn      (bus.Release_V_ap_vld),
    .clrIdx     (bus.Release_V),
    .busyNext_s (busyNext_s)
  );

  // Next-state decode; bank freedom is judged on post-update occupancy so a
  // same-cycle release lets filling resume on the following cycle.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      FILL: begin
        if (lastBeat_s) nextState_s = NOTIFY;
        else            nextState_s = FILL;
      end
      NOTIFY: begin
        if (bus.SyncSig_V_ap_ack) nextState_s = busyNext_s[~curBank_r] ? WAIT : FILL;
        else                      nextState_s = NOTIFY;
      end
      WAIT: begin
        if (!busyNext_s[curBank_r]) nextState_s = FILL;
        else                        nextState_s = WAIT;
      end
      default: nextState_s = FILL;
    endcase
  end

  // State, bank pointer and handshake outputs.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_r   <= FILL;
      curBank_r <= 1'b0;
      ready_r   <= 1'b0;
      vld_r     <= 1'b0;
      sync_r    <= 1'b0;
      tileCnt_r <= 16'd0;
    end else begin
      state_r <= nextState_s;
      ready_r <= (nextState_s == FILL);
      vld_r   <= (nextState_s == NOTIFY);
      if (lastBeat_s) sync_r <= curBank_r;
      if (ackTake_s) begin
        curBank_r <= ~curBank_r;
        tileCnt_r <= tileCnt_r + 16'd1;
      end
    end
  end

  // Registered BRAM write port and word offset.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      offset_r <= '0;
      ce_r     <= 1'b0;
      addr_r   <= '0;
      data_r   <= '0;
    end else begin
      ce_r <= accept_s;
      if (accept_s) begin
        addr_r   <= {curBank_r, offset_r};
        data_r   <= bus.reluRes_V_Data_V_TDATA;
        offset_r <= lastBeat_s ? '0 : offset_r + OFF_STEP;
      end
    end
  end

  assign bus.reluRes_V_Data_V_TREADY = ready_r;
  assign bus.SyncSig_V               = sync_r;
  assign bus.SyncSig_V_ap_vld        = vld_r;
  assign bus.ActBuf_Data_V_address0  = addr_r;
  assign bus.ActBuf_Data_V_ce0       = ce_r;
  assign bus.ActBuf_Data_V_we0       = ce_r;
  assign bus.ActBuf_Data_V_d0        = data_r;
  assign tile_cnt                    = tileCnt_r;

endmodule

// File: tb/tb_layer1_write_act.sv
// Bench for layer1_write_act with 4-word tiles: directed handoff scenarios and a
// randomized run checked against a sent-word queue and a PE/BRAM model.
module tb_layer1_write_act;
  import layer1_pkg::*;

  localparam int TW = 4;
  localparam int DW = 64;
  localparam int AW = 10;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic [15:0] tile_cnt;

  layer1_write_act_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  layer1_write_act #(.DWIDTH(DW), .AWIDTH(AW), .TILE_WORDS(TW)) dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .bus      (bus),
    .tile_cnt (tile_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  wire          rdy  = bus.reluRes_V_Data_V_TREADY;
  wire          vld  = bus.SyncSig_V_ap_vld;
  wire          sync = bus.SyncSig_V;
  wire          ce   = bus.ActBuf_Data_V_ce0;
  wire          we   = bus.ActBuf_Data_V_we0;
  wire [AW-1:0] addr = bus.ActBuf_Data_V_address0;
  wire [DW-1:0] d0   = bus.ActBuf_Data_V_d0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge ap_clk) if (ce && we) mem[addr] <= d0;

  int vectors = 0;
  int miscompares = 0;

  task automatic tick();
    @(negedge ap_clk);
  endtask

  task automatic setIn(input logic v, input logic [DW-1:0] w, input logic a,
                       input logic rv, input logic rb);
    bus.reluRes_V_Data_V_TVALID = v;
    bus.reluRes_V_Data_V_TDATA  = w;
    bus.SyncSig_V_ap_ack        = a;
    bus.Release_V_ap_vld        = rv;
    bus.Release_V               = rb;
  endtask

  task automatic fill_tile(input logic bank, input logic [DW-1:0] first);
    logic [DW-1:0] w;
    for (int i = 0; i < TW; i++) begin
      vectors++;
      if (rdy !== 1'b1) begin
        miscompares++; $display("FAIL fill_ready word %0d: got %b want 1", i, rdy);
      end
      w = first + 64'h11 * i;
      setIn(1'b1, w, 1'b0, 1'b0, 1'b0);
      tick();
      vectors++;
      if ({ce, we, addr, d0} !== {1'b1, 1'b1, bank, i[AW-2:0], w}) begin
        miscompares++;
        $display("FAIL fill_write word %0d: got ce=%b we=%b addr=%0d d0=%h want addr=%0d d0=%h",
                 i, ce, we, addr, d0, {bank, i[AW-2:0]}, w);
      end
      vectors++;
      if (vld !== (i == TW-1)) begin
        miscompares++; $display("FAIL fill_vld word %0d: got %b want %b", i, vld, i == TW-1);
      end
    end
    setIn(1'b0, '0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({sync, rdy} !== {bank, 1'b0}) begin
      miscompares++; $display("FAIL fill_notify: got sync=%b rdy=%b want sync=%b rdy=0", sync, rdy, bank);
    end
  endtask

  task automatic ack_tile(input logic rv, input logic rb, input logic expRdy, input logic [15:0] expCnt);
    setIn(1'b0, '0, 1'b1, rv, rb);
    tick();
    setIn(1'b0, '0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({vld, rdy, ce, tile_cnt} !== {1'b0, expRdy, 1'b0, expCnt}) begin
      miscompares++;
      $display("FAIL ack: got vld=%b rdy=%b ce=%b tile_cnt=%0d want vld=0 rdy=%b ce=0 tile_cnt=%0d",
               vld, rdy, ce, tile_cnt, expRdy, expCnt);
    end
  endtask

  task automatic release_bank(input logic b, input logic expRdy);
    setIn(1'b0, '0, 1'b0, 1'b1, b);
    tick();
    setIn(1'b0, '0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (rdy !== expRdy) begin
      miscompares++; $display("FAIL release bank %0d: got rdy=%b want %b", b, rdy, expRdy);
    end
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    setIn(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    vectors++;
    if ({rdy, vld, ce, we, addr, d0, sync, tile_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b ce=%b we=%b addr=%0d d0=%h sync=%b cnt=%0d want all 0",
               rdy, vld, ce, we, addr, d0, sync, tile_cnt);
    end
    ap_rst = 1'b0;
    tick();
    vectors++;
    if (rdy !== 1'b1) begin
      miscompares++; $display("FAIL reset_release_ready: got %b want 1", rdy);
    end
  endtask

  task automatic test_basic_handoff();
    fill_tile(1'b0, 64'h11);
    ack_tile(1'b0, 1'b0, 1'b1, 16'd1);
    fill_tile(1'b1, 64'h55);
    ack_tile(1'b0, 1'b0, 1'b0, 16'd2);
  endtask

  task automatic test_both_busy();
    setIn(1'b1, 64'h99, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if ({rdy, ce, vld} !== 3'b000) begin
        miscompares++; $display("FAIL both_busy cycle %0d: got rdy=%b ce=%b vld=%b want 000", i, rdy, ce, vld);
      end
    end
    release_bank(1'b0, 1'b1);
    fill_tile(1'b0, 64'h99);
  endtask

  task automatic test_ack_stall();
    setIn(1'b1, 64'hEE, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if ({vld, sync, rdy, ce} !== 4'b1000) begin
        miscompares++;
        $display("FAIL ack_stall cycle %0d: got vld=%b sync=%b rdy=%b ce=%b want 1000", i, vld, sync, rdy, ce);
      end
    end
    setIn(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_same_cycle();
    ack_tile(1'b1, 1'b0, 1'b0, 16'd3);   // release of the bank being acked loses
    release_bank(1'b1, 1'b1);
    fill_tile(1'b1, 64'hA1);
    ack_tile(1'b0, 1'b0, 1'b0, 16'd4);   // bank 0 must still be busy
    release_bank(1'b0, 1'b1);
    fill_tile(1'b0, 64'hB1);
    ack_tile(1'b1, 1'b1, 1'b1, 16'd5);   // release of the other bank applies
  endtask

  task automatic test_reset_mid_tile();
    for (int i = 0; i < 2; i++) begin
      setIn(1'b1, 64'hD0 + i, 1'b0, 1'b0, 1'b0);
      tick();
      vectors++;
      if ({ce, addr} !== {1'b1, 1'b1, i[AW-2:0]}) begin
        miscompares++; $display("FAIL partial_write %0d: got ce=%b addr=%0d", i, ce, addr);
      end
    end
    ap_rst = 1'b1;
    setIn(1'b0, '0, 1'b1, 1'b1, 1'b1);
    tick();
    vectors++;
    if ({rdy, vld, ce, we, addr, d0, sync, tile_cnt} !== '0) begin
      miscompares++;
      $display("FAIL midtile_reset: got rdy=%b vld=%b ce=%b addr=%0d d0=%h sync=%b cnt=%0d want all 0",
               rdy, vld, ce, addr, d0, sync, tile_cnt);
    end
    ap_rst = 1'b0;
    setIn(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    vectors++;
    if ({rdy, vld, tile_cnt} !== {1'b1, 1'b0, 16'd0}) begin
      miscompares++; $display("FAIL after_reset: got rdy=%b vld=%b cnt=%0d want 1 0 0", rdy, vld, tile_cnt);
    end
    release_bank(1'b0, 1'b1);
    fill_tile(1'b0, 64'hC1);
    ack_tile(1'b0, 1'b0, 1'b1, 16'd1);
  endtask

  typedef struct { logic bank; int cnt; } held_t;

  task automatic test_random();
    logic [DW-1:0] sent[$];
    held_t         held[$];
    held_t         h;
    int            handoffs = 0;
    int            cyc = 0;
    logic          expBank = 1'b0;
    logic          a, rv, rb, v;
    logic [DW-1:0] w;
    logic [AW-1:0] ad;

    ap_rst = 1'b1;
    setIn(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    ap_rst = 1'b0;
    tick();
    while ((handoffs < 20 || held.size() > 0) && cyc < 4000) begin
      a = 1'b0; rv = 1'b0; rb = 1'b0;
      if (ce) begin
        foreach (held[k]) begin
          vectors++;
          if (addr[AW-1] === held[k].bank) begin
            miscompares++; $display("FAIL write_to_held_bank: addr=%0d while bank %0d held", addr, held[k].bank);
          end
        end
      end
      if (held.size() > 0) begin
        if (held[0].cnt == 0) begin
          for (int i = 0; i < TW; i++) begin
            ad = {held[0].bank, i[AW-2:0]};
            vectors++;
            if (sent.size() == 0 || mem[ad] !== sent[0]) begin
              miscompares++;
              $display("FAIL tile_content handoff word %0d: got %h want %h", i, mem[ad],
                       (sent.size() > 0) ? sent[0] : '0);
            end
            if (sent.size() > 0) void'(sent.pop_front());
          end
          rv = 1'b1;
          rb = held[0].bank;
          void'(held.pop_front());
        end else begin
          held[0].cnt--;
        end
      end
      if (vld && handoffs < 20 && $urandom_range(0, 2) != 0) begin
        a = 1'b1;
        vectors++;
        if (sync !== expBank) begin
          miscompares++; $display("FAIL handoff_bank %0d: got %b want %b", handoffs, sync, expBank);
        end
        h.bank = sync;
        h.cnt  = int'($urandom_range(1, 8));
        held.push_back(h);
        expBank = ~expBank;
        handoffs++;
      end
      v = 1'($urandom_range(0, 1));
      w = {$urandom, $urandom};
      if (v && rdy) sent.push_back(w);
      setIn(v, w, a, rv, rb);
      tick();
      cyc++;
    end
    setIn(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    vectors++;
    if (handoffs != 20 || held.size() != 0) begin
      miscompares++; $display("FAIL random_timeout: handoffs=%0d held=%0d want 20 0", handoffs, held.size());
    end
    vectors++;
    if (tile_cnt !== 16'd20) begin
      miscompares++; $display("FAIL random_tile_cnt: got %0d want 20", tile_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic_handoff();
    test_both_busy();
    test_ack_stall();
    test_same_cycle();
    test_reset_mid_tile();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
